dpram: RTL and testbench

//  Generic true dual-port synchronous RAM, 2**ADDR_WIDTH words x DATA_WIDTH bits.

---
 rtl/dpram.sv | 49 ++++
 tb/tb_dpram.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dpram.sv
// True dual-port synchronous RAM with a shared clock and registered read data.
// Port A wins a same-address write collision; both ports read old data during a write.
module dpram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Contents come up zeroed from device configuration; reset never touches the array.
  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_q_a;
  logic [DATA_WIDTH-1:0] r_q_b;
  logic                  w_wr_b;

  // A port B write to the address port A is also writing is dropped.
  assign w_wr_b = wren_b && !(wren_a && (address_a == address_b));

  always_ff @(posedge clock) begin
    if (w_wr_b) begin
      r_mem[address_b] <= data_b;
    end
    if (wren_a) begin
      r_mem[address_a] <= data_a;
    end
    if (!reset_n) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      r_q_a <= r_mem[address_a];
      r_q_b <= r_mem[address_b];
    end
  end

  assign q_a = r_q_a;
  assign q_b = r_q_b;

endmodule

// File: tb/tb_dpram.sv
// Randomized and directed checks of dpram against an array-based reference model.
module tb_dpram;

  localparam int unsigned Aw = 9;
  localparam int unsigned Dw = 8;
  localparam int unsigned Depth = 2 ** Aw;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [Aw-1:0] address_a, address_b;
  logic [Dw-1:0] data_a, data_b;
  logic          wren_a, wren_b;
  logic [Dw-1:0] q_a, q_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [Dw-1:0] mdl [Depth];
  logic [Dw-1:0] exp_qa, exp_qb;

  dpram #(
    .ADDR_WIDTH(Aw),
    .DATA_WIDTH(Dw)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .address_a(address_a),
    .data_a   (data_a),
    .wren_a   (wren_a),
    .q_a      (q_a),
    .address_b(address_b),
    .data_b   (data_b),
    .wren_b   (wren_b),
    .q_b      (q_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [Dw-1:0] obs, input logic [Dw-1:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock edge: apply inputs, advance the model, compare both outputs.
  task automatic cycle(input logic rst_n, input logic [Aw-1:0] aa, input logic [Dw-1:0] da,
                       input logic wa, input logic [Aw-1:0] ab, input logic [Dw-1:0] db,
                       input logic wb);
    reset_n   = rst_n;
    address_a = aa;
    data_a    = da;
    wren_a    = wa;
    address_b = ab;
    data_b    = db;
    wren_b    = wb;
    @(posedge clock);
    exp_qa = rst_n ? mdl[aa] : '0;
    exp_qb = rst_n ? mdl[ab] : '0;
    if (wb && !(wa && aa == ab)) mdl[ab] = db;
    if (wa) mdl[aa] = da;
    #1;
    chk("q_a", q_a, exp_qa);
    chk("q_b", q_b, exp_qb);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < int'(Depth); i++) mdl[i] = '0;

    // Hold reset while sweeping zeros through port A; writes still land during reset.
    for (int i = 0; i < int'(Depth); i++) begin
      cycle(1'b0, Aw'(i), 8'h00, 1'b1, Aw'(i), 8'h00, 1'b0);
    end
    chk("reset_q_a", q_a, 8'h00);
    chk("reset_q_b", q_b, 8'h00);

    // Reset clears outputs but not the array.
    cycle(1'b1, 9'h050, 8'h5A, 1'b1, 9'h000, 8'h00, 1'b0);
    cycle(1'b0, 9'h050, 8'h00, 1'b0, 9'h050, 8'h00, 1'b0);
    chk("rst_clr_a", q_a, 8'h00);
    chk("rst_clr_b", q_b, 8'h00);
    cycle(1'b1, 9'h050, 8'h00, 1'b0, 9'h050, 8'h00, 1'b0);
    chk("rst_keep_a", q_a, 8'h5A);
    chk("rst_keep_b", q_b, 8'h5A);

    // Basic write A, read B.
    cycle(1'b1, 9'h003, 8'hA5, 1'b1, 9'h000, 8'h00, 1'b0);
    cycle(1'b1, 9'h000, 8'h00, 1'b0, 9'h003, 8'h00, 1'b0);
    chk("basic", q_b, 8'hA5);

    // Mixed-port read-during-write.
    cycle(1'b1, 9'h010, 8'h3C, 1'b1, 9'h010, 8'h00, 1'b0);
    chk("mixed_old", q_b, 8'h00);
    cycle(1'b1, 9'h000, 8'h00, 1'b0, 9'h010, 8'h00, 1'b0);
    chk("mixed_new", q_b, 8'h3C);

    // Write-write collision at the top address.
    cycle(1'b1, 9'h1FF, 8'h11, 1'b1, 9'h1FF, 8'h22, 1'b1);
    cycle(1'b1, 9'h1FF, 8'h00, 1'b0, 9'h1FF, 8'h00, 1'b0);
    chk("coll_a", q_a, 8'h11);
    chk("coll_b", q_b, 8'h11);

    // Same-port read-during-write.
    cycle(1'b1, 9'h020, 8'h77, 1'b1, 9'h000, 8'h00, 1'b0);
    chk("rdw_old", q_a, 8'h00);
    cycle(1'b1, 9'h020, 8'h00, 1'b0, 9'h000, 8'h00, 1'b0);
    chk("rdw_new", q_a, 8'h77);

    // Full fill through A, read back through B across the 0x1FF -> 0x000 boundary.
    for (int i = 0; i < int'(Depth); i++) begin
      cycle(1'b1, Aw'(i), Dw'(i & 8'hFF), 1'b1, 9'h000, 8'h00, 1'b0);
    end
    for (int i = 0; i < int'(Depth) + 2; i++) begin
      cycle(1'b1, 9'h000, 8'h00, 1'b0, Aw'((i + 510) % int'(Depth)), 8'h00, 1'b0);
      chk("fill", q_b, Dw'(((i + 510) % int'(Depth)) & 8'hFF));
    end

    // Random traffic, biased towards a few addresses to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      logic          r;
      logic [Aw-1:0] aa, ab;
      r  = ($urandom_range(0, 31) != 0);
      aa = $urandom_range(0, 1) ? Aw'($urandom_range(0, 3)) : Aw'($urandom);
      ab = $urandom_range(0, 1) ? Aw'($urandom_range(0, 3)) : Aw'($urandom);
      cycle(r, aa, Dw'($urandom), 1'($urandom), ab, Dw'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
